// File: rtl/vector_alu_seq.sv
// vector_alu_seq: lane-serial add/sub/mul/div over two snapshotted vectors,
// writing the low result half to A3 and then the high half to A4.
module vector_alu_seq #(
   parameter int LANES           = 32,
   parameter int WIDTH           = 16,
   parameter int LANES_PER_CYCLE = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [1:0]                   opcode,
   input  logic [LANES-1:0][WIDTH-1:0]  A1,
   input  logic [LANES-1:0][WIDTH-1:0]  A2,
   output logic [LANES-1:0][WIDTH-1:0]  dataOut,
   output logic                         write3,
   output logic                         write4,
   output logic                         busy,
   output logic                         done
);
   localparam int CW = $clog2(LANES);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] EXEC  = 3'd1;
   localparam logic [2:0] WB_LO = 3'd2;
   localparam logic [2:0] WB_HI = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]                  state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [1:0]                  op_q, op_d;
   logic [LANES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, lo_q, lo_d, hi_q, hi_d;

   function automatic logic [2*WIDTH-1:0] lane_op(input logic [1:0] op,
                                                  input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b);
      logic signed [WIDTH:0]     s;
      logic signed [2*WIDTH-1:0] p;
      logic signed [WIDTH-1:0]   q, m;
      s = op[0] ? (WIDTH+1)'(a) - (WIDTH+1)'(b) : (WIDTH+1)'(a) + (WIDTH+1)'(b);
      p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
      q = a / b;
      m = a % b;
      if (!op[1]) return {{(WIDTH-1){s[WIDTH]}}, s};
      if (!op[0]) return p;
      if (b == '0) return {a, {WIDTH{1'b1}}};
      // most-negative / -1 overflows the quotient; wrap instead of trapping
      if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) return {{WIDTH{1'b0}}, a};
      return {m, q};
   endfunction

   always_comb begin
      logic [2*WIDTH-1:0] r;
      r       = '0;
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = EXEC;
            cnt_d   = '0;
            op_d    = opcode;
            a_d     = A1;
            b_d     = A2;
         end
         EXEC: begin
            for (int i = 0; i < LANES_PER_CYCLE; i++) begin
               r = lane_op(op_q, a_q[cnt_q + CW'(i)], b_q[cnt_q + CW'(i)]);
               lo_d[cnt_q + CW'(i)] = r[WIDTH-1:0];
               hi_d[cnt_q + CW'(i)] = r[2*WIDTH-1:WIDTH];
            end
            cnt_d   = cnt_q + CW'(LANES_PER_CYCLE);
            state_d = (cnt_q == CW'(LANES - LANES_PER_CYCLE)) ? WB_LO : EXEC;
         end
         WB_LO:   state_d = WB_HI;
         WB_HI:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
      end
   end

   assign busy    = state_q != IDLE;
   assign write3  = state_q == WB_LO;
   assign write4  = state_q == WB_HI;
   assign done    = state_q == DONE;
   assign dataOut = (state_q == WB_HI) ? hi_q : lo_q;
endmodule

// File: tb/tb_vector_alu_seq.sv
// tb_vector_alu_seq: table vectors plus a write-back scoreboard for vector_alu_seq.
module tb_vector_alu_seq;
   localparam int L = 32;
   localparam int W = 16;
   typedef logic [L-1:0][W-1:0] vec_t;
   typedef struct {
      logic [1:0]   op;
      int           lane;
      logic [W-1:0] a, b, lo, hi;
   } tv_t;

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [1:0] opcode = '0;
   vec_t       A1 = '0, A2 = '0, data_out;
   logic       write3, write4, busy, done;
   int         applied = 0, miscmp = 0;
   vec_t       lo_exp[$], hi_exp[$];
   vec_t       got_lo, got_hi;

   always #5 clk = ~clk;

   vector_alu_seq #(.LANES(L), .WIDTH(W), .LANES_PER_CYCLE(4)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .A1(A1), .A2(A2),
      .dataOut(data_out), .write3(write3), .write4(write4), .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
      applied++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         2'd0: return 32'(sa + sb);
         2'd1: return 32'(sa - sb);
         2'd2: return 32'(sa * sb);
         default: begin
            if (sb == 0) return {a, 16'hFFFF};
            if (sa == -32768 && sb == -1) return {16'h0000, 16'h8000};
            return {16'(sa % sb), 16'(sa / sb)};
         end
      endcase
   endfunction

   function automatic vec_t base(input int seed, input bit second);
      vec_t v;
      for (int i = 0; i < L; i++)
         v[i] = second ? 16'(i * 97 - 1500 + seed) : 16'(i * 1031 - 9000 + seed);
      return v;
   endfunction

   always @(negedge clk) begin
      if (write3) begin
         got_lo = data_out;
         if (lo_exp.size() == 0) chk("unexpected_write3", 1, 0);
         else chk("sb_lo", data_out, lo_exp.pop_front());
      end
      if (write4) begin
         got_hi = data_out;
         if (hi_exp.size() == 0) chk("unexpected_write4", 1, 0);
         else chk("sb_hi", data_out, hi_exp.pop_front());
      end
   end

   // mode 0: plain run, 1: operand/opcode change plus second start mid-op, 2: reset mid-op
   task automatic run_op(input logic [1:0] op, input vec_t a, input vec_t b, input int mode);
      vec_t le, he;
      logic [2*W-1:0] r;
      int c3 = 0, c4 = 0, cd = 0, n3 = 0, n4 = 0, nd = 0;
      for (int i = 0; i < L; i++) begin
         r = model(op, a[i], b[i]);
         le[i] = r[W-1:0];
         he[i] = r[2*W-1:W];
      end
      if (mode != 2) begin
         lo_exp.push_back(le);
         hi_exp.push_back(he);
      end
      A1 = a; A2 = b; opcode = op; start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            chk("busy_after_start", busy, 1);
         end
         if (write3) begin n3++; c3 = k; end
         if (write4) begin n4++; c4 = k; end
         if (done)   begin nd++; cd = k; end
         if (mode == 1 && k == 3) begin A1 = ~a; opcode = op + 2'd1; end
         if (mode == 1 && k == 4) start = 1'b1;
         if (mode == 1 && k == 5) start = 1'b0;
         if (mode == 2 && k == 5) begin
            rst = 1'b1;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_strobes", {write3, write4, done}, 0);
            chk("rst_data", data_out, 0);
         end
         if (mode == 2 && k == 6) rst = 1'b0;
         if (k == 12) chk("busy_idle", busy, 0);
      end
      if (mode == 2) chk("no_strobe_after_abort", n3 + n4 + nd, 0);
      else begin
         chk("write3_cycle", c3, 9);
         chk("write4_cycle", c4, 10);
         chk("done_cycle", cd, 11);
         chk("one_each", {8'(n3), 8'(n4), 8'(nd)}, {8'd1, 8'd1, 8'd1});
      end
   endtask

   initial begin
      tv_t  tbl[7];
      vec_t a, b, e;
      tbl[0] = '{2'd0, 0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000};
      tbl[1] = '{2'd1, 1,  16'h8000, 16'h0001, 16'h7FFF, 16'hFFFF};
      tbl[2] = '{2'd2, 5,  16'hFED4, 16'h00C8, 16'h15A0, 16'hFFFF};
      tbl[3] = '{2'd2, 31, 16'h8000, 16'h8000, 16'h0000, 16'h4000};
      tbl[4] = '{2'd3, 2,  16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF};
      tbl[5] = '{2'd3, 3,  16'h0007, 16'h0000, 16'hFFFF, 16'h0007};
      tbl[6] = '{2'd3, 4,  16'h8000, 16'hFFFF, 16'h8000, 16'h0000};
      repeat (2) @(negedge clk);
      chk("reset_strobes", {busy, done, write3, write4}, 0);
      chk("reset_data", data_out, 0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < L; i++) begin
         a[i] = 16'(i);
         b[i] = 16'd100;
         e[i] = 16'(100 + i);
      end
      run_op(2'd0, a, b, 0);
      chk("add_lanes_lo", got_lo, e);
      chk("add_lanes_hi", got_hi, 0);
      for (int t = 0; t < 7; t++) begin
         a = base(t * 13, 0);
         b = base(t * 7 + 1, 1);
         a[tbl[t].lane] = tbl[t].a;
         b[tbl[t].lane] = tbl[t].b;
         run_op(tbl[t].op, a, b, 0);
         chk($sformatf("tbl%0d_lo", t), got_lo[tbl[t].lane], tbl[t].lo);
         chk($sformatf("tbl%0d_hi", t), got_hi[tbl[t].lane], tbl[t].hi);
      end
      run_op(2'd2, base(321, 0), base(55, 1), 1);
      run_op(2'd3, base(9, 0), base(4, 1), 2);
      run_op(2'd1, base(777, 0), base(-60, 1), 0);
      run_op(2'd3, base(-4000, 0), base(3, 1), 0);
      chk("sb_empty", lo_exp.size() + hi_exp.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
      $finish;
   end
endmodule
